fp_addsub_arbiter: RTL and testbench
====================================

Name: fp_addsub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one Float_Add unit between N requesters. Each requester presents an IEEE-754 single-precision operand pair and an add/sub opcode. The block picks one requester, launches the adder with a one-cycle start, waits for the adder's valid, and returns the sum to the granted requester with a done pulse. A watchdog ends a hung operation with an error response.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before error completion (>=2)
IDW, 2, requester-id width, equals clog2(N)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active low
req  input  N  per-requester request level
op  input  N  per-requester opcode: 0=add, 1=sub (X-Y)
x_in  input  32*N  operand X, requester i at [32i+31:32i]
y_in  input  32*N  operand Y, same packing
gnt  output  N  one-hot, one-cycle pulse when request accepted
done  output  N  one-hot, one-cycle pulse when result is ready
result  output  32  result word, meaningful only while done!=0
err  output  1  qualifies done: 1 means timeout
busy  output  1  high in every state except IDLE
fa_start  output  1  start pulse to Float_Add
fa_x  output  32  X to Float_Add
fa_y  output  32  Y to Float_Add
fa_valid  input  1  Float_Add valid
fa_sum  input  32  Float_Add sum

Behaviour:
- Reset: sampled on rising clk while rst=0. It overrides every other event, including mid-operation.
  - All outputs go to 0 and the state goes to IDLE.
  - RR pointer ptr=0 and the watchdog counter is cleared.
  - Any in-flight adder result is discarded.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If req is not 0, select the first set req bit scanning from ptr upward, modulo N. Call it id.
  - Latch x=x_in[id] and y=y_in[id].
  - If op[id]=1, latch fa_y={~y[31],y[30:0]}; otherwise fa_y=y.
  - Set fa_x=x and go to LAUNCH.
  - If req=0, stay in IDLE.
  - fa_valid is ignored in IDLE.
- LAUNCH (exactly 1 cycle):
  - fa_start=1 and gnt[id]=1.
  - Clear the counter and go to WAIT.
- WAIT:
  - fa_start=0. fa_x and fa_y hold steady until the next LAUNCH.
  - If fa_valid=1, capture fa_sum into result, set err=0, go to RESP.
  - Otherwise, if counter==TIMEOUT-1, set result=32'h7FC00000 (qNaN), err=1, go to RESP.
  - Otherwise, counter+1.
  - If valid arrives on the same cycle the watchdog expires, valid wins.
- RESP (exactly 1 cycle):
  - done[id]=1 with result and err stable.
  - ptr=(id+1) mod N.
  - Go to IDLE.
  - result and err hold their values after RESP until overwritten.
- Handshake:
  - A requester holds req, op, x_in and y_in stable until it sees gnt. Operands are sampled only in IDLE.
  - req still high after done counts as a new request; it is queued behind the other requesters by the RR pointer.
  - Dropping req before gnt withdraws the request if not yet selected. Once selected, the operation completes regardless of req.
- Minimum turnaround: 4 cycles (IDLE→LAUNCH→WAIT→RESP) plus adder latency. Back-to-back requests need no idle gap beyond the IDLE cycle.
- Only one operation is in flight. A late fa_valid after a timeout is ignored, because the block is in IDLE or the next LAUNCH clears context.
- Fairness: every continuously asserted req is granted within N operations.

Test Plan:
- Single add:
  - Stimulus: req[0]=1, op=0, X=0x40700000 (3.75), Y=0xC0D80000 (-6.75).
  - Required: gnt[0] pulse coincides with a 1-cycle fa_start, fa_x=0x40700000, fa_y=0xC0D80000.
  - Required: done[0] with result=0xC0400000 (-3.0), err=0, busy low the cycle after done.
- Subtract:
  - Stimulus: req[2]=1, op=1, X=0x40D80000 (6.75), Y=0x40700000 (3.75).
  - Required: fa_y=0xC0700000, done[2] with result=0x40400000 (3.0).
- Round-robin:
  - Stimulus: after reset, req=4'b1111 held with X=0x40D80000, Y=0x40700000.
  - Required: grant order 0,1,2,3,0. Each done returns 0x41280000 (10.5). Exactly one fa_start per grant.
- Timeout:
  - Stimulus: adder model never asserts fa_valid.
  - Required: done[id] after TIMEOUT WAIT cycles with err=1, result=0x7FC00000.
  - Required: the next request completes normally with err=0, even if a stale fa_valid pulse arrives while in IDLE.
- Reset mid-WAIT:
  - Stimulus: drop rst during WAIT.
  - Required: next cycle all outputs are 0, state is IDLE, ptr=0.
  - Required: then with req[1] and req[3] asserted together, req[1] is granted first.
- Valid/timeout collision:
  - Stimulus: fa_valid rises exactly at counter==TIMEOUT-1 with fa_sum=0x41280000.
  - Required: result=0x41280000, err=0.

Source files
------------

// File: rtl/fp_addsub_arbiter.sv
// Round-robin front end that shares one Float_Add unit between N requesters.
// One operation is in flight at a time: IDLE picks a requester and latches its
// operands, LAUNCH pulses fa_start/gnt, WAIT collects fa_sum (or times out),
// and RESP pulses done for the granted requester.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-low reset
//   req, op              per-requester request level and opcode (1 = X-Y)
//   x_in, y_in           packed operands, requester i at [32i+31:32i]
//   gnt, done            one-hot single-cycle accept / completion pulses
//   result, err          completion data; err=1 marks a watchdog timeout
//   busy                 high in every state except IDLE
//   fa_start, fa_x, fa_y request side of the shared adder
//   fa_valid, fa_sum     response side of the shared adder
module fp_addsub_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDW     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    op,
  input  logic [32*N-1:0] x_in,
  input  logic [32*N-1:0] y_in,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [31:0]     result,
  output logic            err,
  output logic            busy,
  output logic            fa_start,
  output logic [31:0]     fa_x,
  output logic [31:0]     fa_y,
  input  logic            fa_valid,
  input  logic [31:0]     fa_sum
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   gnt_d, done_d;
  logic [31:0]    result_d, fa_x_d, fa_y_d;
  logic           err_d, busy_d, fa_start_d;

  // Round-robin pick: first set req bit scanning upward from ptr, wrapping at N.
  logic           sel_found;
  logic [IDW-1:0] sel_id;
  int unsigned    scan_idx;

  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = (32'(ptr_q) + k) % N;
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(scan_idx);
      end
    end
  end

  logic [31:0] sel_x, sel_y;
  assign sel_x = x_in[32*sel_id +: 32];
  assign sel_y = y_in[32*sel_id +: 32];

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    done_d     = '0;
    fa_start_d = 1'b0;
    result_d   = result;
    err_d      = err;
    fa_x_d     = fa_x;
    fa_y_d     = fa_y;

    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          id_d          = sel_id;
          fa_x_d        = sel_x;
          // Subtraction is an add with Y's sign flipped.
          fa_y_d        = op[sel_id] ? {~sel_y[31], sel_y[30:0]} : sel_y;
          // Outputs are registered, so the LAUNCH-cycle pulses are set here.
          fa_start_d    = 1'b1;
          gnt_d[sel_id] = 1'b1;
          state_d       = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A valid on the watchdog's last cycle still wins.
        if (fa_valid) begin
          result_d     = fa_sum;
          err_d        = 1'b0;
          done_d[id_q] = 1'b1;
          state_d      = StResp;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d     = QNAN;
          err_d        = 1'b1;
          done_d[id_q] = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp: begin
        ptr_d   = IDW'((32'(id_q) + 1) % N);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      id_q     <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt      <= '0;
      done     <= '0;
      result   <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      fa_start <= 1'b0;
      fa_x     <= '0;
      fa_y     <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt      <= gnt_d;
      done     <= done_d;
      result   <= result_d;
      err      <= err_d;
      busy     <= busy_d;
      fa_start <= fa_start_d;
      fa_x     <= fa_x_d;
      fa_y     <= fa_y_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench for fp_addsub_arbiter. A transaction-level model tracks
// the round-robin pointer and computes expected sums with real arithmetic; the
// bench also plays the Float_Add unit with a programmable latency.
module tb_fp_addsub_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned IDW     = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, op;
  logic [32*N-1:0] x_in, y_in;
  logic [N-1:0]    gnt, done;
  logic [31:0]     result, fa_x, fa_y, fa_sum;
  logic            err, busy, fa_start, fa_valid;

  int n_checks = 0;
  int n_errors = 0;
  int ptr_m    = 0;
  int last_gid = -1;

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .x_in     (x_in),
    .y_in     (y_in),
    .gnt      (gnt),
    .done     (done),
    .result   (result),
    .err      (err),
    .busy     (busy),
    .fa_start (fa_start),
    .fa_x     (fa_x),
    .fa_y     (fa_y),
    .fa_valid (fa_valid),
    .fa_sum   (fa_sum)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Single-precision <-> real for normal numbers and zero.
  function automatic real f2r(input logic [31:0] b);
    real r = 1.0 + real'(b[22:0]) / 8388608.0;
    int  e = int'(b[30:23]) - 127;
    if (b[30:0] == 31'd0) return 0.0;
    for (; e > 0; e--) r = r * 2.0;
    for (; e < 0; e++) r = r / 2.0;
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Quarter-integers in [-16,16] keep every sum exact.
  function automatic logic [31:0] rand_val();
    int k = int'($urandom_range(0, 128)) - 64;
    return r2f(real'(k) / 4.0);
  endfunction

  function automatic int pick_m();
    for (int k = 0; k < N; k++) if (req[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic o, input logic [31:0] x, input logic [31:0] y);
    req[i]             = 1'b1;
    op[i]              = o;
    x_in[32*i +: 32]   = x;
    y_in[32*i +: 32]   = y;
  endtask

  // mode: 0 hold inputs after gnt, 1 drop the granted req, 2 randomise.
  // lat: adder latency in cycles after gnt; 0 or >TIMEOUT means it never answers.
  task automatic run_op(input int lat, input int mode);
    int          id, n, kd, starts;
    logic [31:0] xs, ys, ey, exp_res, stub_sum;
    logic        exp_err;
    id = pick_m();
    if (id < 0) return;
    xs      = x_in[32*id +: 32];
    ys      = y_in[32*id +: 32];
    ey      = op[id] ? {~ys[31], ys[30:0]} : ys;
    exp_err = (lat <= 0 || lat > int'(TIMEOUT));
    exp_res = exp_err ? 32'h7FC0_0000 : r2f(f2r(xs) + (op[id] ? -f2r(ys) : f2r(ys)));
    kd      = (exp_err ? int'(TIMEOUT) : lat) + 1;

    n = 0;
    while (gnt == '0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("gnt", 32'(gnt), 32'(1 << id));
    check("fa_start", 32'(fa_start), 32'd1);
    check("fa_x", fa_x, xs);
    check("fa_y", fa_y, ey);
    check("busy_launch", 32'(busy), 32'd1);
    last_gid = -1;
    for (int b = 0; b < N; b++) if (gnt[b]) last_gid = b;
    stub_sum = r2f(f2r(fa_x) + f2r(fa_y));

    if (mode == 1) req[id] = 1'b0;
    if (mode == 2) begin
      if ($urandom_range(0, 1) == 1) set_req(id, 1'($urandom_range(0, 1)), rand_val(), rand_val());
      else req[id] = 1'b0;
      for (int j = 0; j < N; j++)
        if (j != id && !req[j] && $urandom_range(0, 2) == 0)
          set_req(j, 1'($urandom_range(0, 1)), rand_val(), rand_val());
    end

    starts = 0;
    n      = 0;
    for (int k = 1; k <= int'(TIMEOUT) + 3; k++) begin
      @(negedge clk);
      if (fa_start) starts++;
      if (done != '0) begin
        n = k;
        break;
      end
      fa_valid = (k == lat);
      fa_sum   = (k == lat) ? stub_sum : $urandom;
    end
    fa_valid = 1'b0;
    check("done_cycle", 32'(n), 32'(kd));
    check("done", 32'(done), 32'(1 << id));
    check("result", result, exp_res);
    check("err", 32'(err), 32'(exp_err));
    check("busy_wait", 32'(busy), 32'd1);
    check("one_start", 32'(starts), 32'd0);
    ptr_m = (id + 1) % N;

    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("result_hold", result, exp_res);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fa_start"}, 32'(fa_start), 32'd0);
    check({tag, "_fa_x"}, fa_x, 32'd0);
    check({tag, "_fa_y"}, fa_y, 32'd0);
  endtask

  initial begin
    int n;
    int lat;
    rst = 1'b0; req = '0; op = '0; x_in = '0; y_in = '0; fa_valid = 1'b0; fa_sum = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    ptr_m = 0;

    // Single add: 3.75 + -6.75
    set_req(0, 1'b0, 32'h4070_0000, 32'hC0D8_0000);
    run_op(3, 1);
    check("add_const", result, 32'hC040_0000);

    // Subtract: 6.75 - 3.75
    set_req(2, 1'b1, 32'h40D8_0000, 32'h4070_0000);
    run_op(2, 1);
    check("sub_fay", fa_y, 32'hC070_0000);
    check("sub_const", result, 32'h4040_0000);

    // Round-robin with all four requesting from a fresh reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ptr_m = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h40D8_0000, 32'h4070_0000);
    for (int k = 0; k < 5; k++) begin
      run_op(1 + k, 0);
      check("rr_order", 32'(last_gid), 32'(k % N));
      check("rr_const", result, 32'h4128_0000);
    end
    req = '0;

    // Timeout, then a stale valid in IDLE, then a normal operation.
    set_req(1, 1'b0, 32'h40D8_0000, 32'h4070_0000);
    run_op(0, 1);
    fa_valid = 1'b1;
    fa_sum   = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("stale_busy", 32'(busy), 32'd0);
    check("stale_done", 32'(done), 32'd0);
    fa_valid = 1'b0;
    set_req(2, 1'b0, 32'h4070_0000, 32'hC0D8_0000);
    run_op(4, 1);
    check("post_to_err", 32'(err), 32'd0);
    check("post_to_res", result, 32'hC040_0000);

    // Valid arriving on the watchdog's final cycle.
    set_req(3, 1'b0, 32'h40D8_0000, 32'h4070_0000);
    run_op(int'(TIMEOUT), 1);
    check("coll_res", result, 32'h4128_0000);
    check("coll_err", 32'(err), 32'd0);

    // Reset during WAIT; pointer is advanced to 2 first so the restart is visible.
    set_req(1, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
    run_op(2, 1);
    set_req(2, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
    n = 0;
    while (gnt == '0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rw_gnt", 32'(gnt), 32'h4);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_wait");
    rst = 1'b1;
    ptr_m = 0;
    set_req(1, 1'b0, 32'h40D8_0000, 32'h4070_0000);
    set_req(3, 1'b1, 32'h40D8_0000, 32'h4070_0000);
    run_op(2, 1);
    check("rw_first", 32'(last_gid), 32'd1);
    run_op(1, 1);
    check("rw_second", 32'(last_gid), 32'd3);

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      if (req == '0) set_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                             rand_val(), rand_val());
      case ($urandom_range(0, 9))
        0:       lat = 0;
        1:       lat = int'(TIMEOUT);
        default: lat = int'($urandom_range(1, 6));
      endcase
      run_op(lat, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
